// File: rtl/fetch_align_ctrl.sv
// Fetch sequencer and halfword aligner: issues word-aligned reads, tracks a halfword PC and
// presents each raw instruction (compressed or 32-bit, possibly word-straddling) exactly once.
module fetch_align_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_data_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_comp_o
);

  localparam logic [2:0] StDispatch = 3'd0;
  localparam logic [2:0] StReq      = 3'd1;
  localparam logic [2:0] StWait     = 3'd2;
  localparam logic [2:0] StOut      = 3'd3;
  localparam logic [2:0] StDrop     = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] hw_buf_q, hw_buf_d;
  logic        hw_valid_q, hw_valid_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_comp_q, inst_comp_d;

  logic [31:0] pc_word;
  logic        drop_pending;

  assign pc_word = {pc_q[31:2], 2'b00};

  // A read is still in flight if it was granted earlier (WAIT/DROP without data) or right now.
  assign drop_pending = ((state_q == StWait) && !mem_rvalid_i) ||
                        ((state_q == StDrop) && !mem_rvalid_i) ||
                        ((state_q == StReq) && mem_gnt_i);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hw_buf_d     = hw_buf_q;
    hw_valid_d   = hw_valid_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    inst_comp_d  = inst_comp_q;

    case (state_q)
      StDispatch: begin
        if (pc_q[1] && hw_valid_q && (hw_buf_q[1:0] != 2'b11)) begin
          inst_data_d  = {16'h0000, hw_buf_q};
          inst_comp_d  = 1'b1;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          hw_valid_d   = 1'b0;
          state_d      = StOut;
        end else begin
          // With the low half already buffered, only the following word is needed.
          mem_addr_d = (pc_q[1] && hw_valid_q) ? pc_word + 32'd4 : pc_word;
          mem_req_d  = 1'b1;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (mem_rvalid_i) begin
          if (!pc_q[1]) begin
            if (mem_rdata_i[1:0] != 2'b11) begin
              inst_data_d = {16'h0000, mem_rdata_i[15:0]};
              inst_comp_d = 1'b1;
              hw_buf_d    = mem_rdata_i[31:16];
              hw_valid_d  = 1'b1;
            end else begin
              inst_data_d = mem_rdata_i;
              inst_comp_d = 1'b0;
              hw_valid_d  = 1'b0;
            end
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = StOut;
          end else if (hw_valid_q) begin
            inst_data_d  = {mem_rdata_i[15:0], hw_buf_q};
            inst_comp_d  = 1'b0;
            hw_buf_d     = mem_rdata_i[31:16];
            hw_valid_d   = 1'b1;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = StOut;
          end else begin
            hw_buf_d   = mem_rdata_i[31:16];
            hw_valid_d = 1'b1;
            state_d    = StDispatch;
          end
        end
      end
      StOut: begin
        if (inst_ready_i) begin
          inst_valid_d = 1'b0;
          pc_d         = pc_q + (inst_comp_q ? 32'd2 : 32'd4);
          state_d      = StDispatch;
        end
      end
      StDrop: begin
        if (mem_rvalid_i) begin
          state_d = StDispatch;
        end
      end
      default: begin
        state_d = StDispatch;
      end
    endcase

    if (redirect_valid_i) begin
      pc_d         = redirect_pc_i & ~32'd1;
      hw_valid_d   = 1'b0;
      inst_valid_d = 1'b0;
      mem_req_d    = 1'b0;
      state_d      = drop_pending ? StDrop : StDispatch;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StDispatch;
      pc_q         <= RESET_PC & ~32'd1;
      hw_buf_q     <= 16'h0000;
      hw_valid_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'h0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= 32'h0;
      inst_pc_q    <= 32'h0;
      inst_comp_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hw_buf_q     <= hw_buf_d;
      hw_valid_q   <= hw_valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
      inst_comp_q  <= inst_comp_d;
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign inst_valid_o = inst_valid_q;
  assign inst_data_o  = inst_data_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_comp_o  = inst_comp_q;

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Scoreboard bench for fetch_align_ctrl: a program-order model over a memory image predicts the
// instruction stream; a monitor pops and compares on every accepted instruction.
module tb_fetch_align_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid, mem_req, mem_gnt, mem_rvalid;
  logic        inst_valid, inst_ready, inst_comp;
  logic [31:0] redirect_pc, mem_addr, mem_rdata, inst_data, inst_pc;

  always #5 clk = ~clk;

  fetch_align_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .mem_req_o       (mem_req),
    .mem_addr_o      (mem_addr),
    .mem_gnt_i       (mem_gnt),
    .mem_rvalid_i    (mem_rvalid),
    .mem_rdata_i     (mem_rdata),
    .inst_valid_o    (inst_valid),
    .inst_ready_i    (inst_ready),
    .inst_data_o     (inst_data),
    .inst_pc_o       (inst_pc),
    .inst_comp_o     (inst_comp)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        comp;
  } inst_t;

  logic [31:0] mem [256];
  inst_t       exp_q[$];
  logic [31:0] gnt_log[$];
  int          acc_cyc[$];
  logic [31:0] model_pc;
  int          n_tests = 0, n_fail = 0, n_acc = 0, cyc = 0;
  logic        rnd = 1'b0;
  int          lat = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Memory is 1 KiB, aliased across the address space.
  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Next instruction in program order at model_pc.
  task automatic push_one();
    inst_t e;
    logic [15:0] lo;
    lo   = hw(model_pc);
    e.pc = model_pc;
    if (lo[1:0] != 2'b11) begin
      e.data   = {16'h0000, lo};
      e.comp   = 1'b1;
      model_pc = model_pc + 32'd2;
    end else begin
      e.data   = {hw(model_pc + 32'd2), lo};
      e.comp   = 1'b0;
      model_pc = model_pc + 32'd4;
    end
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] gl(input int i);
    if (i < gnt_log.size()) return gnt_log[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] rand_tgt();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
    return 32'($urandom_range(0, 1023));
  endfunction

  // Call just after a rising edge with inst_ready already set for the coming edge.
  task automatic issue_redirect(input logic [31:0] tgt);
    inst_t keep;
    if (inst_valid && inst_ready && exp_q.size() > 0) begin
      keep = exp_q[0];
      exp_q.delete();
      exp_q.push_back(keep);
    end else begin
      exp_q.delete();
    end
    model_pc       = tgt & ~32'd1;
    redirect_pc    = tgt;
    redirect_valid = 1'b1;
  endtask

  // Monitor: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    inst_t e;
    if (rst_n && inst_valid && inst_ready) begin
      acc_cyc.push_back(cyc);
      n_acc++;
      check("inst_expected", 128'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("inst_data", inst_data, e.data);
        check("inst_pc", inst_pc, e.pc);
        check("inst_comp", inst_comp, e.comp);
      end
    end
    if (rst_n && mem_req && mem_gnt) gnt_log.push_back(mem_addr);
  end

  // Handshake protocol checks.
  logic        p_hold_inst = 1'b0, p_hold_req = 1'b0, p_comp;
  logic [31:0] p_data, p_pc, p_addr;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) check("addr_aligned", mem_addr[1:0], 0);
      if (inst_valid) check("no_req_while_valid", mem_req, 0);
      if (p_hold_inst) begin
        check("hold_valid", inst_valid, 1);
        check("hold_data", {inst_data, inst_pc, inst_comp}, {p_data, p_pc, p_comp});
      end
      if (p_hold_req) check("hold_req", {mem_req, mem_addr}, {1'b1, p_addr});
      p_hold_inst = inst_valid && !inst_ready && !redirect_valid;
      p_hold_req  = mem_req && !mem_gnt && !redirect_valid;
      p_data = inst_data;
      p_pc   = inst_pc;
      p_comp = inst_comp;
      p_addr = mem_addr;
    end else begin
      p_hold_inst = 1'b0;
      p_hold_req  = 1'b0;
    end
  end

  // Memory responder: one read at a time, rvalid at least one cycle after the grant.
  initial begin
    logic        g;
    logic [31:0] a;
    int          d;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      if (rst_n && mem_req) begin
        g = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (g) begin
          a = mem_addr;
          d = rnd ? int'($urandom_range(0, 3)) : lat;
          mem_gnt = 1'b1;
          @(posedge clk); #1;
          mem_gnt = 1'b0;
          repeat (d) begin @(posedge clk); #1; end
          mem_rvalid = 1'b1;
          mem_rdata  = mem[a[9:2]];
          @(posedge clk); #1;
          mem_rvalid = 1'b0;
          mem_rdata  = 32'h0;
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    exp_q.delete(); gnt_log.delete(); acc_cyc.delete();
    model_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {mem_req, mem_addr, inst_valid, inst_data, inst_pc, inst_comp}, 0);
    rst_n = 1'b1;
  endtask

  // Returns just after a rising edge, so inputs may be changed safely.
  task automatic wait_drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_gnts(input int n, input int max);
    for (int i = 0; i < max && gnt_log.size() < n; i++) @(negedge clk);
    check("gnt_count", 128'(gnt_log.size() >= n), 1);
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 32'h0;
  endtask

  initial begin
    int acc0;
    logic [15:0] h;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // 32-bit instruction at reset PC
    clear_mem(); mem[0] = 32'h0000_0513;
    do_reset(); push_one(); inst_ready = 1'b1;
    wait_drain(60); inst_ready = 1'b0;
    wait_gnts(2, 60);
    check("t1_addr0", gl(0), 32'h0);
    check("t1_addr1", gl(1), 32'h4);

    // Two compressed instructions from one word
    clear_mem(); mem[0] = 32'h4501_4481;
    do_reset(); push_one(); push_one(); inst_ready = 1'b1;
    wait_drain(60); inst_ready = 1'b0;
    wait_gnts(2, 60);
    check("t2_addr0", gl(0), 32'h0);
    check("t2_addr1", gl(1), 32'h4);
    check("t2_gap", acc_cyc.size() > 1 ? acc_cyc[1] - acc_cyc[0] : -1, 2);

    // Straddling 32-bit instruction followed by a buffered compressed one
    clear_mem(); mem[0] = 32'h0513_4501; mem[1] = 32'h4501_0000;
    do_reset(); repeat (3) push_one(); inst_ready = 1'b1;
    wait_drain(80); inst_ready = 1'b0;
    wait_gnts(3, 60);
    check("t3_addr1", gl(1), 32'h4);
    check("t3_addr2", gl(2), 32'h8);
    check("t3_gap", acc_cyc.size() > 2 ? acc_cyc[2] - acc_cyc[1] : -1, 2);

    // Redirect to an odd halfword while a read is outstanding
    clear_mem(); mem[0] = 32'h0000_0513; mem[1] = 32'hDEAD_BEEF; mem[64] = 32'h4481_0000;
    lat = 5;
    do_reset(); push_one(); inst_ready = 1'b1;
    wait_drain(60);
    wait_gnts(2, 60);
    @(posedge clk); #1;
    issue_redirect(32'h0000_0102);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    push_one();
    wait_drain(80); inst_ready = 1'b0;
    check("t4_addr2", gl(2), 32'h100);
    lat = 0;

    // Back-pressure holds the instruction and blocks fetching
    clear_mem(); mem[0] = 32'h0000_0513;
    do_reset(); push_one();
    for (int i = 0; i < 40 && !inst_valid; i++) @(negedge clk);
    check("t5_valid", inst_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check("t5_data", {inst_valid, inst_data, inst_pc}, {1'b1, 32'h0000_0513, 32'h0});
      check("t5_req", mem_req, 0);
    end
    @(posedge clk); #1;
    inst_ready = 1'b1;
    wait_drain(20); inst_ready = 1'b0;

    // Asynchronous reset during an outstanding read
    clear_mem(); mem[0] = 32'h0000_0513; mem[1] = 32'h0000_0001;
    lat = 6;
    do_reset(); push_one(); inst_ready = 1'b1;
    wait_drain(60);
    wait_gnts(2, 60);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_rst", {mem_req, mem_addr, inst_valid, inst_data, inst_pc, inst_comp}, 0);
    lat = 0;
    exp_q.delete(); gnt_log.delete(); model_pc = 32'h0; push_one();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_drain(80); inst_ready = 1'b0;
    check("t6_restart_addr", gl(0), 32'h0);

    // Straddle across the top of the address space
    clear_mem(); mem[255] = 32'h0513_0001; mem[0] = 32'h4481_0000;
    do_reset();
    issue_redirect(32'hFFFF_FFFF);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    push_one(); push_one(); inst_ready = 1'b1;
    wait_drain(80); inst_ready = 1'b0;
    check("t7_addr0", gl(0), 32'hFFFF_FFFC);
    check("t7_addr1", gl(1), 32'h0);

    // Randomized program, back-pressure, grant/latency and redirects
    foreach (mem[i]) begin
      for (int k = 0; k < 2; k++) begin
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
        else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
        if (k == 0) mem[i][15:0] = h; else mem[i][31:16] = h;
      end
    end
    do_reset();
    rnd  = 1'b1;
    acc0 = n_acc;
    repeat (4000) begin
      @(posedge clk); #1;
      inst_ready = ($urandom_range(0, 3) != 0);
      if (redirect_valid) redirect_valid = 1'b0;
      else if ($urandom_range(0, 39) == 0) issue_redirect(rand_tgt());
      while (exp_q.size() < 6) push_one();
    end
    rnd = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    check("rand_progress", 128'(n_acc - acc0 >= 300), 1);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_align_ctrl.md
Name: fetch_align_ctrl

Overview:
Fetch sequencer and halfword aligner that sits in front of Decompression_Unit. It issues word-aligned instruction-memory reads and tracks a halfword-aligned PC. It splits or joins halfwords so that each instruction is presented once, in its raw form, on a valid/ready interface. It handles compressed instructions, 32-bit instructions straddling a word boundary, back-pressure and branch redirects with stale-response dropping.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (bit 0 ignored)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
redirect_valid  input  1  branch/jump redirect, one-cycle pulse
redirect_pc  input  32  redirect target; bit 0 ignored
mem_req  output  1  read request; held until granted
mem_addr  output  32  word-aligned read address; bits[1:0]=0
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  read data valid; at most one outstanding read
mem_rdata  input  32  read data
inst_valid  output  1  raw instruction available
inst_ready  input  1  consumer accepts instruction
inst_data  output  32  raw instruction; compressed in [15:0], [31:16]=0
inst_pc  output  32  PC of inst_data
inst_comp  output  1  1 = 16-bit instruction (low bits != 2'b11)

Behaviour:
- Reset (rst=0, async): pc=RESET_PC&~1, hw_valid=0, state=DISPATCH, all outputs 0.
- Internal state: pc; 16-bit hw_buf with hw_valid, holding the upper halfword of word (pc&~3) when pc[1]=1. All outputs are registered.
- FSM states: DISPATCH, REQ, WAIT, OUT, DROP.
- DISPATCH:
  - If pc[1]=1, hw_valid=1 and hw_buf[1:0]!=2'b11: load inst_data={16'h0,hw_buf}, inst_comp=1, clear hw_valid, go to OUT. No fetch.
  - Otherwise: mem_addr = pc&~3 if pc[1]=0 or hw_valid=0; else (pc&~3)+4. Set mem_req=1, go to REQ.
- REQ: mem_req and mem_addr stay stable until mem_gnt=1. On grant, mem_req=0 next cycle and go to WAIT.
- WAIT, on mem_rvalid:
  - pc[1]=0, rdata[1:0]!=2'b11: emit {16'h0,rdata[15:0]}, comp=1; hw_buf=rdata[31:16], hw_valid=1.
  - pc[1]=0, 32-bit: emit rdata, comp=0; hw_valid=0.
  - pc[1]=1, hw_valid=1 (straddle): emit {rdata[15:0],hw_buf}, comp=0; hw_buf=rdata[31:16], hw_valid=1.
  - pc[1]=1, hw_valid=0 (odd redirect target): hw_buf=rdata[31:16], hw_valid=1; no emit; go to DISPATCH.
  - Any emit: inst_pc=pc, go to OUT. Valid rises the cycle after mem_rvalid.
- OUT: inst_valid=1 with inst_data, inst_pc and inst_comp held stable until inst_ready=1. On accept, pc += 2 (comp) or 4, inst_valid=0 next cycle, go to DISPATCH.
  - Buffered compressed instruction: next inst_valid 2 cycles after accept.
  - Otherwise: mem_req 2 cycles after accept.
- No new mem_req while inst_valid=1.
- Redirect (highest priority, any state):
  - Next cycle: pc=redirect_pc&~1, hw_valid=0, inst_valid=0, mem_req=0.
  - From WAIT, or from REQ with mem_gnt in the same cycle: go to DROP.
  - From any other state: go to DISPATCH.
- Redirect with inst_ready in OUT in the same cycle: the consumer takes the instruction; pc comes from the redirect.
- DROP: discard the next mem_rvalid, then go to DISPATCH. A redirect arriving in DROP updates pc and stays in DROP. If it coincides with mem_rvalid, the response is discarded and the FSM goes to DISPATCH.
- Arithmetic: pc and mem_addr are mod 2^32. A straddle at pc=32'hFFFF_FFFE fetches address 0.
- mem_rvalid outside WAIT/DROP is ignored.

Test Plan:
- Reset (RESET_PC=0), mem[0]=32'h0000_0513 -> mem_addr=0 requested; inst_data=32'h0000_0513, inst_pc=0, inst_comp=0; after accept, mem_addr=4.
- mem[0]=32'h4501_4481 -> outputs 32'h0000_4481 @pc 0 comp=1, then 32'h0000_4501 @pc 2 comp=1, 2 cycles after first accept, with exactly one grant; then mem_addr=4.
- mem[0]=32'h0513_4501, mem[4]=32'h4501_0000 -> 32'h0000_4501 @0 comp=1; 32'h0000_0513 @2 comp=0 (straddle, fetch 4); 32'h0000_4501 @6 comp=1 with no fetch; next mem_addr=8.
- Redirect to 32'h102 while the read of addr 4 is outstanding; stale rvalid data 32'hDEAD_BEEF -> not emitted; fetch 32'h100 (upper half buffered), then output @pc 32'h102.
- inst_ready=0 for 5 cycles in OUT -> inst_valid, inst_data and inst_pc stable; mem_req=0 throughout.
- rst=0 asserted mid-WAIT -> outputs 0 immediately (async); after release, fetch restarts at RESET_PC; late rvalid ignored.
